tlb_ctrl: RTL
=============

# tlb_ctrl

Sequencer sitting in front of the shared set-associative TLB. It arbitrates translation requests from the instruction-fetch and load/store units. It drives the TLB's read-then-compare lookup and, on a miss, hands the VPN to the page-table walker. It then fills the TLB with the returned leaf PTE and forwards flush requests at a safe point.

## Interface

Parameters:

- `VPN_WIDTH`, 20 — VPN width; matches the TLB's VPN width.
- `PTE_WIDTH`, 32 — stored PTE width; matches the TLB's PTE width.

Ports:

- `clk` in 1 — clock; the only clock.
- `rstn` in 1 — asynchronous, active-low reset.
- `req0_valid`, `req1_valid` in 1 — lookup request (0 = instruction side, 1 = data side).
- `req0_vpn`, `req1_vpn` in `VPN_WIDTH` — VPN; held stable while valid and not ready.
- `req0_ready`, `req1_ready` out 1 — grant pulse.
- `rsp0_valid`, `rsp1_valid` out 1 — response pulse.
- `rsp_pte` out `PTE_WIDTH` — translated PTE, shared by both requesters.
- `rsp_spage` out 3 — superpage bits, shared.
- `rsp_fault` out 1 — walker reported a fault, shared.
- `tlb_cs`, `tlb_we` out 1 — TLB chip select and write enable.
- `tlb_vpn` out `VPN_WIDTH` — TLB lookup/fill VPN.
- `tlb_spage_in` out 3 — fill superpage bits.
- `tlb_pte_in` out `PTE_WIDTH` — fill PTE.
- `tlb_hit` in 1 — TLB hit; valid the cycle after a read.
- `tlb_spage_out` in 3 — TLB superpage output.
- `tlb_pte_out` in `PTE_WIDTH` — TLB PTE output.
- `tlb_flush_req` out 1 — TLB flush pulse.
- `ptw_req` out 1 — walk request, level.
- `ptw_vpn` out `VPN_WIDTH` — walk VPN.
- `ptw_done` in 1 — walk complete pulse.
- `ptw_pte` in `PTE_WIDTH` — walker result PTE.
- `ptw_spage` in 3 — walker result superpage bits.
- `ptw_fault` in 1 — walker fault.
- `flush_req` in 1 — sfence.vma pulse from the core.
- `flush_ack` out 1 — flush forwarded pulse.

## Operation

States: IDLE, LOOKUP, WALK, FILL.

Registered context: `id` (requester), `vpn_q`, `pte_q`, `spage_q`, `flush_pend`, `last_grant` (reset 1, so requester 0 wins first).

IDLE:
- If `flush_pend` or `flush_req`:
  - `tlb_flush_req`=1 and `flush_ack`=1 for this cycle.
  - Clear `flush_pend`.
  - No grant this cycle.
- Else if any `reqN_valid`:
  - Grant one requester: the single requester if only one is valid; else the one != `last_grant`.
  - `reqN_ready`=1; `tlb_cs`=1, `tlb_we`=0, `tlb_vpn`=`reqN_vpn`.
  - Latch `id`, `vpn_q`; update `last_grant`; go to LOOKUP.

LOOKUP:
- `tlb_hit`=1: `rsp{id}_valid`=1, `rsp_pte`=`tlb_pte_out`, `rsp_spage`=`tlb_spage_out`, `rsp_fault`=0; go to IDLE.
- Miss: `ptw_req`=1, `ptw_vpn`=`vpn_q`; go to WALK.

WALK:
- Hold `ptw_req`=1 and `ptw_vpn`=`vpn_q` until `ptw_done`.
- On `ptw_done`:
  - Latch `pte_q`, `spage_q`.
  - `ptw_fault`=1: `rsp{id}_valid`=1, `rsp_fault`=1, `rsp_pte`=0, `rsp_spage`=0; go to IDLE, no fill.
  - Else go to FILL.

FILL:
- `rsp{id}_valid`=1, `rsp_pte`=`pte_q`, `rsp_spage`=`spage_q`, `rsp_fault`=0.
- If `flush_pend`=0: `tlb_cs`=1, `tlb_we`=1, `tlb_vpn`=`vpn_q`, `tlb_pte_in`=`pte_q`, `tlb_spage_in`=`spage_q`.
- If `flush_pend`=1: no write; the walk result may be stale, so it is returned but not cached.
- Go to IDLE.

Flush handling:
- `flush_req` in any state other than IDLE sets `flush_pend`.
- A flush is never dropped; back-to-back flushes merge into one.

Outputs and constraints:
- All outputs not listed for the current state are 0.
- At most one request is outstanding in total.
- Each requester must not re-request before its `rsp` pulse.

## Timing

- Reset: every output 0; state IDLE; `flush_pend`=0; `last_grant`=1. Asynchronous reset mid-walk abandons the walk; `ptw_req` drops immediately.
- Hit: grant at cycle T; `rsp` at T+1; next grant possible at T+2.
- Miss: `ptw_req` rises at T+1. With `ptw_done` at W ≥ T+2, `rsp` and the fill are at W+1; next grant possible at W+2.
- Fault: `rsp` with `rsp_fault` at W; no FILL cycle.
- Flush in IDLE: `tlb_flush_req` in the same cycle as `flush_req`.
- Flush while busy: `tlb_flush_req` in the first IDLE cycle after return, ahead of any pending request.
- Simultaneous `flush_req` and requests in IDLE: flush wins; grant on the next cycle.
- `ptw_done` is ignored outside WALK.

## Test plan

- Hit: `req0_valid`, vpn 0x12345, `tlb_hit`=1, `tlb_pte_out`=0x0ABCD0CF at T+1 -> `req0_ready` at T; `rsp0_valid` at T+1 with that PTE; `rsp_fault`=0.
- Miss/fill: `req1` vpn 0x00400, `tlb_hit`=0, `ptw_done` at T+5 with PTE 0x20000CF, spage 3'b001 -> `ptw_req` high T+1..T+5; at T+6 `tlb_we`=1, `tlb_vpn`=0x00400, `rsp1_valid`=1.
- Fault: miss with `ptw_fault`=1 -> `rsp_fault`=1, `rsp_pte`=0, no `tlb_we`.
- Round-robin: both requesters held valid for 4 back-to-back hits -> grants 0,1,0,1; each `rsp` goes to the matching requester only.
- Flush during walk: `flush_req` in WALK -> FILL returns the PTE with `tlb_cs`=0; `tlb_flush_req` and `flush_ack` in the next IDLE cycle, before a waiting `req0` is granted.
- Reset mid-walk: drop `rstn` in WALK -> `ptw_req`, `rsp*`, `tlb_cs` all 0 asynchronously; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/tlb_ctrl.sv
// tlb_ctrl: sequences TLB lookups for the fetch and load/store requesters,
// launches a page-table walk on a miss, fills the TLB with the walk result
// and forwards sfence.vma flushes only when no translation is in flight.
module tlb_ctrl #(
   parameter int VPN_WIDTH = 20,
   parameter int PTE_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 req0_valid,
   input  logic [VPN_WIDTH-1:0] req0_vpn,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [VPN_WIDTH-1:0] req1_vpn,
   output logic                 req1_ready,
   output logic                 rsp0_valid,
   output logic                 rsp1_valid,
   output logic [PTE_WIDTH-1:0] rsp_pte,
   output logic [2:0]           rsp_spage,
   output logic                 rsp_fault,
   output logic                 tlb_cs,
   output logic                 tlb_we,
   output logic [VPN_WIDTH-1:0] tlb_vpn,
   output logic [2:0]           tlb_spage_in,
   output logic [PTE_WIDTH-1:0] tlb_pte_in,
   input  logic                 tlb_hit,
   input  logic [2:0]           tlb_spage_out,
   input  logic [PTE_WIDTH-1:0] tlb_pte_out,
   output logic                 tlb_flush_req,
   output logic                 ptw_req,
   output logic [VPN_WIDTH-1:0] ptw_vpn,
   input  logic                 ptw_done,
   input  logic [PTE_WIDTH-1:0] ptw_pte,
   input  logic [2:0]           ptw_spage,
   input  logic                 ptw_fault,
   input  logic                 flush_req,
   output logic                 flush_ack
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_WALK,
      ST_FILL
   } state_t;

   state_t                 r_state,      w_next_state;
   logic                   r_id,         w_next_id;
   logic [VPN_WIDTH-1:0]   r_vpn_q,      w_next_vpn_q;
   logic [PTE_WIDTH-1:0]   r_pte_q,      w_next_pte_q;
   logic [2:0]             r_spage_q,    w_next_spage_q;
   logic                   r_flush_pend, w_next_flush_pend;
   logic                   r_last_grant, w_next_last_grant;

   // Requester 1 wins when it is alone, or when both ask and 0 went last.
   logic w_gnt1;
   logic w_rsp;

   assign w_gnt1 = req1_valid & (~req0_valid | ~r_last_grant);

   // State and context registers; last_grant resets to 1 so requester 0 wins first.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= ST_IDLE;
         r_id         <= 1'b0;
         r_vpn_q      <= '0;
         r_pte_q      <= '0;
         r_spage_q    <= '0;
         r_flush_pend <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         // NOTE: non-blocking here so every register samples pre-edge values.
         r_state      <= w_next_state;
         r_id         <= w_next_id;
         r_vpn_q      <= w_next_vpn_q;
         r_pte_q      <= w_next_pte_q;
         r_spage_q    <= w_next_spage_q;
         r_flush_pend <= w_next_flush_pend;
         r_last_grant <= w_next_last_grant;
      end
   end

   // Next-state, context update and all outputs for the current state.
   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one unassigned (no latch).
      w_next_state      = r_state;
      w_next_id         = r_id;
      w_next_vpn_q      = r_vpn_q;
      w_next_pte_q      = r_pte_q;
      w_next_spage_q    = r_spage_q;
      w_next_flush_pend = r_flush_pend;
      w_next_last_grant = r_last_grant;
      w_rsp             = 1'b0;
      req0_ready        = 1'b0;
      req1_ready        = 1'b0;
      rsp0_valid        = 1'b0;
      rsp1_valid        = 1'b0;
      rsp_pte           = '0;
      rsp_spage         = '0;
      rsp_fault         = 1'b0;
      tlb_cs            = 1'b0;
      tlb_we            = 1'b0;
      tlb_vpn           = '0;
      tlb_spage_in      = '0;
      tlb_pte_in        = '0;
      tlb_flush_req     = 1'b0;
      ptw_req           = 1'b0;
      ptw_vpn           = '0;
      flush_ack         = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (r_flush_pend || flush_req) begin
               // Flush takes priority over any waiting request.
               tlb_flush_req     = 1'b1;
               flush_ack         = 1'b1;
               w_next_flush_pend = 1'b0;
            end else if (req0_valid || req1_valid) begin
               req0_ready        = ~w_gnt1;
               req1_ready        = w_gnt1;
               tlb_cs            = 1'b1;
               tlb_vpn           = w_gnt1 ? req1_vpn : req0_vpn;
               w_next_id         = w_gnt1;
               w_next_vpn_q      = w_gnt1 ? req1_vpn : req0_vpn;
               w_next_last_grant = w_gnt1;
               w_next_state      = ST_LOOKUP;
            end
         end

         ST_LOOKUP: begin
            if (tlb_hit) begin
               w_rsp        = 1'b1;
               rsp_pte      = tlb_pte_out;
               rsp_spage    = tlb_spage_out;
               w_next_state = ST_IDLE;
            end else begin
               ptw_req      = 1'b1;
               ptw_vpn      = r_vpn_q;
               w_next_state = ST_WALK;
            end
         end

         ST_WALK: begin
            ptw_req = 1'b1;
            ptw_vpn = r_vpn_q;
            if (ptw_done) begin
               w_next_pte_q   = ptw_pte;
               w_next_spage_q = ptw_spage;
               if (ptw_fault) begin
                  // Faulting walks answer immediately and are never cached.
                  w_rsp        = 1'b1;
                  rsp_fault    = 1'b1;
                  w_next_state = ST_IDLE;
               end else begin
                  w_next_state = ST_FILL;
               end
            end
         end

         ST_FILL: begin
            w_rsp     = 1'b1;
            rsp_pte   = r_pte_q;
            rsp_spage = r_spage_q;
            // A flush seen during the walk may have invalidated this PTE:
            // hand it back but keep it out of the TLB.
            if (!r_flush_pend) begin
               tlb_cs       = 1'b1;
               tlb_we       = 1'b1;
               tlb_vpn      = r_vpn_q;
               tlb_pte_in   = r_pte_q;
               tlb_spage_in = r_spage_q;
            end
            w_next_state = ST_IDLE;
         end

         default: begin
            w_next_state = ST_IDLE;
         end
      endcase

      // Flushes arriving while busy are remembered; repeats merge into one.
      if (r_state != ST_IDLE && flush_req) begin
         w_next_flush_pend = 1'b1;
      end

      rsp0_valid = w_rsp & ~r_id;
      rsp1_valid = w_rsp & r_id;

      // Reset forces every output low at once, independent of the inputs.
      if (!rstn) begin
         req0_ready    = 1'b0;
         req1_ready    = 1'b0;
         rsp0_valid    = 1'b0;
         rsp1_valid    = 1'b0;
         rsp_pte       = '0;
         rsp_spage     = '0;
         rsp_fault     = 1'b0;
         tlb_cs        = 1'b0;
         tlb_we        = 1'b0;
         tlb_vpn       = '0;
         tlb_spage_in  = '0;
         tlb_pte_in    = '0;
         tlb_flush_req = 1'b0;
         ptw_req       = 1'b0;
         ptw_vpn       = '0;
         flush_ack     = 1'b0;
      end
   end

endmodule
